// File: rtl/alu_rr_arbiter_if.sv
// Request/response bundle shared between the two ALU requesters and the arbiter.
// The master modport is the requester side and the slave modport is the arbiter side.
interface alu_rr_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [3:0]  req_op0;
  logic [63:0] req_a0;
  logic [63:0] req_b0;
  logic [3:0]  req_op1;
  logic [63:0] req_a1;
  logic [63:0] req_b1;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [63:0] rsp_data;
  logic        rsp_carry;
  logic        rsp_ovf;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_valid, req_op0, req_a0, req_b0, req_op1, req_a1, req_b1, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_carry, rsp_ovf, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_op0, req_a0, req_b0, req_op1, req_a1, req_b1, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_carry, rsp_ovf, rsp_err, busy
  );
endinterface

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter that shares one 64-bit ALU between the execute stage (port 0)
// and the address/branch-compare unit (port 1). One op in flight: IDLE -> EXEC -> RESP.
module alu_rr_arbiter #(
  parameter int unsigned RR_INIT = 0
) (
  input  logic             clk,
  input  logic             rst,
  alu_rr_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e      state_q, state_d;
  logic        ptr_q;
  logic        gnt_q;
  logic [3:0]  op_q;
  logic [63:0] a_q, b_q;
  logic [63:0] data_q;
  logic        carry_q, ovf_q, err_q;

  logic        idle_gnt;
  logic        accept;
  logic        rsp_hs;
  logic [1:0]  req_ready_c;
  logic [1:0]  rsp_valid_c;

  logic [64:0] add_full, sub_full;
  logic [63:0] alu_res;
  logic        alu_carry, alu_ovf, alu_err;

  // Only a contested cycle consults the pointer.
  always_comb begin
    case (bus.req_valid)
      2'b01:   idle_gnt = 1'b0;
      2'b10:   idle_gnt = 1'b1;
      default: idle_gnt = ptr_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    rsp_hs      = 1'b0;
    req_ready_c = '0;
    rsp_valid_c = '0;
    case (state_q)
      StIdle: begin
        if (!rst && (bus.req_valid != 2'b00)) begin
          req_ready_c[idle_gnt] = 1'b1;
          accept                = 1'b1;
          state_d               = StExec;
        end
      end
      StExec: state_d = StResp;
      StResp: begin
        rsp_valid_c[gnt_q] = 1'b1;
        if (bus.rsp_ready[gnt_q]) begin
          rsp_hs  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign add_full = {1'b0, a_q} + {1'b0, b_q};
  // SUB as A + ~B + 1 so bit 64 reads as "no borrow".
  assign sub_full = {1'b0, a_q} + {1'b0, ~b_q} + 65'd1;

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_err   = 1'b0;
    case (op_q)
      4'd0: begin
        alu_res   = add_full[63:0];
        alu_carry = add_full[64];
        alu_ovf   = (a_q[63] == b_q[63]) && (add_full[63] != a_q[63]);
      end
      4'd1: begin
        alu_res   = sub_full[63:0];
        alu_carry = sub_full[64];
        alu_ovf   = (a_q[63] != b_q[63]) && (sub_full[63] != a_q[63]);
      end
      4'd2:    alu_res = a_q & b_q;
      4'd3:    alu_res = a_q | b_q;
      4'd4:    alu_res = a_q ^ b_q;
      4'd5:    alu_res = {63'd0, $signed(a_q) < $signed(b_q)};
      4'd6:    alu_res = {63'd0, a_q < b_q};
      4'd7:    alu_res = a_q << b_q[5:0];
      4'd8:    alu_res = a_q >> b_q[5:0];
      4'd9:    alu_res = $unsigned($signed(a_q) >>> b_q[5:0]);
      default: alu_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= 1'(RR_INIT);
      gnt_q   <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        gnt_q <= idle_gnt;
        op_q  <= idle_gnt ? bus.req_op1 : bus.req_op0;
        a_q   <= idle_gnt ? bus.req_a1  : bus.req_a0;
        b_q   <= idle_gnt ? bus.req_b1  : bus.req_b0;
      end
      if (state_q == StExec) begin
        data_q  <= alu_res;
        carry_q <= alu_carry;
        ovf_q   <= alu_ovf;
        err_q   <= alu_err;
      end
      if (rsp_hs) ptr_q <= ~gnt_q;
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_c;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_carry = carry_q;
  assign bus.rsp_ovf   = ovf_q;
  assign bus.rsp_err   = err_q;
  assign bus.busy      = (state_q != StIdle);

endmodule
